// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop sync, per-key debounce, press/release strobes, P1/P2 first-press arbiter.
// Define KEYCOND_PRESS_COUNT_EN to add 8-bit per-key press counters on press_cnt.
module key_conditioner #(
  parameter int          NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key_raw_n,
  input  logic                  arb_enable,
  input  logic                  arb_clear,
  output logic [NUM_KEYS-1:0]   key_down,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [1:0]            arb_winner,
  output logic                  arb_valid,
  output logic [8*NUM_KEYS-1:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int               P1_IDX   = 0;
  localparam int               P2_IDX   = 3;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_down;
    logic             r_press;
    logic             r_release;
    logic             w_mismatch;
    logic             w_accept;

    // sync2 is active-low, so equality with the debounced level means disagreement
    assign w_mismatch = (r_sync[1] == r_down);
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync    <= 2'b11;
        r_cnt     <= '0;
        r_down    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync    <= {r_sync[0], key_raw_n[gi]};
        r_press   <= w_accept && !r_down;
        r_release <= w_accept && r_down;
        if (!w_mismatch) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt  <= '0;
          r_down <= ~r_down;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end

    assign key_down[gi]    = r_down;
    assign key_press[gi]   = r_press;
    assign key_release[gi] = r_release;
  end

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic [1:0] r_winner;
  logic [1:0] w_winner_next;
  logic       w_p1;
  logic       w_p2;

  assign w_p1 = key_press[P1_IDX];
  assign w_p2 = key_press[P2_IDX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_winner <= 2'b00;
    end else begin
      r_state  <= w_state_next;
      r_winner <= w_winner_next;
    end
  end

  // arb_clear has priority over any same-cycle press strobe
  always_comb begin
    w_state_next  = r_state;
    w_winner_next = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (arb_clear) begin
          w_winner_next = 2'b00;
        end else if (arb_enable && (w_p1 || w_p2)) begin
          w_state_next  = ST_LOCKED;
          w_winner_next = {w_p2, w_p1};
        end
      end
      ST_LOCKED: begin
        if (arb_clear) begin
          w_state_next  = ST_IDLE;
          w_winner_next = 2'b00;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_winner_next = 2'b00;
      end
    endcase
  end

  assign arb_winner = r_winner;
  assign arb_valid  = (r_state == ST_LOCKED);

`ifdef KEYCOND_PRESS_COUNT_EN
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_pcnt
    logic [7:0] r_pcnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pcnt <= 8'd0;
      end else if (key_press[gi]) begin
        r_pcnt <= r_pcnt + 8'd1;
      end
    end

    assign press_cnt[8*gi +: 8] = r_pcnt;
  end
`else
  assign press_cnt = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4): strobe scoreboard plus arbiter/reset checks.
module tb_key_conditioner;

  localparam int DB  = 4;
  localparam int LAT = DB + 2;

  typedef struct packed {
    logic [3:0]  press;
    logic [3:0]  rel;
    int unsigned cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_raw_n;
  logic        arb_enable;
  logic        arb_clear;
  logic [3:0]  key_down;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [1:0]  arb_winner;
  logic        arb_valid;
  logic [31:0] press_cnt;

  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  ev_t         sb[$];
  logic [7:0]  exp_cnt[4];
  logic [31:0] exp_pc;

  key_conditioner #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw_n(key_raw_n),
    .arb_enable(arb_enable), .arb_clear(arb_clear),
    .key_down(key_down), .key_press(key_press), .key_release(key_release),
    .arb_winner(arb_winner), .arb_valid(arb_valid), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input logic [3:0] mask);
    ev_t e;
    e.press = mask;
    e.rel   = 4'b0;
    e.cyc   = cyc + LAT;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) if (mask[i]) exp_cnt[i] = exp_cnt[i] + 8'd1;
  endtask

  task automatic press_key(input logic [3:0] mask);
    key_raw_n = key_raw_n & ~mask;
    expect_press(mask);
  endtask

  task automatic release_key(input logic [3:0] mask);
    ev_t e;
    key_raw_n = key_raw_n | mask;
    e.press = 4'b0;
    e.rel   = mask;
    e.cyc   = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic pulse_clear();
    arb_clear = 1'b1;
    step(1);
    arb_clear = 1'b0;
  endtask

  // Every strobe cycle must match the oldest expected event, including its cycle stamp
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && ((key_press | key_release) != 4'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'({key_press, key_release}), 64'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_press_rel_cyc", 64'({key_press, key_release, cyc}),
              64'({e.press, e.rel, e.cyc}));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
    key_raw_n  = 4'hF;
    arb_enable = 1'b0;
    arb_clear  = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_down", 64'(key_down), 64'd0);
    check("rst_key_press", 64'(key_press), 64'd0);
    check("rst_key_release", 64'(key_release), 64'd0);
    check("rst_winner", 64'(arb_winner), 64'd0);
    check("rst_valid", 64'(arb_valid), 64'd0);
    check("rst_press_cnt", 64'(press_cnt), 64'd0);
    rst_n = 1'b1;
    step(2);

    // single press and release of key 0
    press_key(4'b0001);
    step(10);
    check("t1_key_down", 64'(key_down), 64'h1);
    release_key(4'b0001);
    step(10);
    check("t1_released", 64'(key_down), 64'h0);

    // 3-cycle glitch on key 1 must be rejected
    key_raw_n[1] = 1'b0;
    step(3);
    key_raw_n[1] = 1'b1;
    step(10);
    check("t2_glitch_down", 64'(key_down), 64'h0);

    // player 2 first, player 1 later does not change the winner
    arb_enable = 1'b1;
    press_key(4'b1000);
    step(8);
    check("t3_winner_p2", 64'(arb_winner), 64'h2);
    check("t3_valid", 64'(arb_valid), 64'h1);
    step(2);
    press_key(4'b0001);
    step(10);
    check("t3_late_p1", 64'(arb_winner), 64'h2);
    pulse_clear();
    check("t3_clear_winner", 64'(arb_winner), 64'h0);
    check("t3_clear_valid", 64'(arb_valid), 64'h0);
    release_key(4'b1001);
    step(10);

    // simultaneous presses give a tie
    press_key(4'b1001);
    step(8);
    check("t4_tie", 64'(arb_winner), 64'h3);
    pulse_clear();
    check("t4_clear", 64'(arb_winner), 64'h0);
    release_key(4'b1001);
    step(10);

    // clear in the same cycle as the press strobe wins
    press_key(4'b0001);
    step(LAT);
    pulse_clear();
    check("clear_wins_winner", 64'(arb_winner), 64'h0);
    step(3);
    check("clear_wins_valid", 64'(arb_valid), 64'h0);
    release_key(4'b0001);
    step(10);

    // disabled arbiter ignores presses; held key at enable does not arbitrate
    arb_enable = 1'b0;
    press_key(4'b0001);
    step(10);
    check("t5_disabled", 64'(arb_winner), 64'h0);
    arb_enable = 1'b1;
    step(5);
    check("t5_held_no_arb", 64'(arb_winner), 64'h0);
    press_key(4'b1000);
    step(8);
    check("t5_lock_p2", 64'(arb_winner), 64'h2);

    // async reset mid-debounce and mid-lock
    key_raw_n[1] = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
    #1;
    check("t5_rst_key_down", 64'(key_down), 64'h0);
    check("t5_rst_winner", 64'(arb_winner), 64'h0);
    check("t5_rst_valid", 64'(arb_valid), 64'h0);
    check("t5_rst_press_cnt", 64'(press_cnt), 64'h0);
    key_raw_n[1] = 1'b1;
    key_raw_n[3] = 1'b1;
    arb_enable   = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_press(4'b0001);
    step(10);
    check("held_through_reset", 64'(key_down), 64'h1);
    release_key(4'b0001);
    step(10);

    // 257 presses of key 2
    repeat (257) begin
      press_key(4'b0100);
      step(LAT + 1);
      release_key(4'b0100);
      step(LAT + 1);
    end
    step(5);
`ifdef KEYCOND_PRESS_COUNT_EN
    for (int i = 0; i < 4; i++) exp_pc[8*i +: 8] = exp_cnt[i];
`else
    exp_pc = 32'd0;
`endif
    check("t6_press_cnt", 64'(press_cnt), 64'(exp_pc));
    check("t6_key2_cnt", 64'(press_cnt[23:16]), 64'(exp_pc[23:16]));

    step(10);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
